// File: rtl/des_perm_pipe.sv
// des_perm_pipe: elastic DES initial-permutation / inverse-permutation pipeline.
// Each transaction is permuted on entry and then moves through PIPE_STAGES valid/ready register stages.
module des_perm_pipe #(
  parameter int unsigned PIPE_STAGES = 2,
  parameter bit          OUT_SWAP    = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [63:0] DATA_IN,
  input  logic        MODE_IN,
  input  logic [3:0]  TAG_IN,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] LEFT,
  output logic [31:0] RIGHT,
  output logic [3:0]  TAG_OUT,
  output logic [2:0]  OCCUPANCY
);

  localparam int unsigned LAST = PIPE_STAGES - 1;

  if ((PIPE_STAGES < 1) || (PIPE_STAGES > 4)) begin : g_bad_stages
    $error("des_perm_pipe: PIPE_STAGES must be in 1..4");
  end

  // DES bit n lives at vector index 64-n; table entries are generated from their row/column pattern.
  function automatic logic [63:0] ip_fwd(input logic [63:0] x);
    logic [63:0] r;
    int unsigned row;
    int unsigned col;
    int unsigned src;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      row = i / 8;
      col = i % 8;
      src = (row < 4) ? (58 + 2 * row - 8 * col) : (57 + 2 * (row - 4) - 8 * col);
      r[6'(63 - i)] = x[6'(64 - src)];
    end
    return r;
  endfunction

  function automatic logic [63:0] ip_inv(input logic [63:0] x);
    logic [63:0] r;
    int unsigned row;
    int unsigned col;
    int unsigned src;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      row = i / 8;
      col = i % 8;
      src = ((col % 2) == 0) ? (40 - row + 4 * col) : (8 - row + 4 * (col - 1));
      r[6'(63 - i)] = x[6'(64 - src)];
    end
    return r;
  endfunction

  logic [63:0]            perm_w;
  logic [PIPE_STAGES-1:0] valid_q;
  logic [PIPE_STAGES-1:0] ld;
  logic [63:0]            data_q [PIPE_STAGES];
  logic [3:0]             tag_q  [PIPE_STAGES];
  logic [2:0]             occ_q;
  logic [2:0]             occ_d;
  logic                   in_fire;
  logic                   out_fire;

  always_comb begin
    perm_w = MODE_IN ? ip_inv(DATA_IN) : ip_fwd(DATA_IN);
  end

  always_comb begin
    OUT_VALID = valid_q[LAST] & ~RESET;
    IN_READY  = ld[0] & ~RESET;
    in_fire   = IN_VALID & IN_READY;
    out_fire  = OUT_VALID & OUT_READY;
  end

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    logic        up_valid;
    logic [63:0] up_data;
    logic [3:0]  up_tag;

    // Flattened form of "empty or downstream advances": a stage is blocked only when it and
    // every later stage are full with the output stalled. Avoids a comb chain through ld.
    always_comb begin
      ld[k] = ~(&valid_q[LAST:k]) | OUT_READY;
    end

    if (k == 0) begin : g_head
      always_comb begin
        up_valid = IN_VALID;
        up_data  = perm_w;
        up_tag   = TAG_IN;
      end
    end else begin : g_body
      always_comb begin
        up_valid = valid_q[k-1];
        up_data  = data_q[k-1];
        up_tag   = tag_q[k-1];
      end
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        tag_q[k]   <= '0;
      end else if (ld[k]) begin
        valid_q[k] <= up_valid;
        if (up_valid) begin
          data_q[k] <= up_data;
          tag_q[k]  <= up_tag;
        end
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (in_fire && !out_fire) begin
      occ_d = occ_q + 3'd1;
    end else if (!in_fire && out_fire) begin
      occ_d = occ_q - 3'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  always_comb begin
    LEFT      = OUT_SWAP ? data_q[LAST][31:0]  : data_q[LAST][63:32];
    RIGHT     = OUT_SWAP ? data_q[LAST][63:32] : data_q[LAST][31:0];
    TAG_OUT   = tag_q[LAST];
    OCCUPANCY = occ_q;
  end

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed bench for des_perm_pipe: three instances (2 stages, 4 stages, 1 stage with half swap)
// exercised by the same scenario tasks.
module tb_des_perm_pipe;

  logic        clk;
  logic        rst       [3];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [63:0] din       [3];
  logic        mode      [3];
  logic [3:0]  tin       [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [31:0] left      [3];
  logic [31:0] right     [3];
  logic [3:0]  tag_out   [3];
  logic [2:0]  occ       [3];

  int checks = 0;
  int passes = 0;

  int IPT[64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                  62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                  57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                  61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int IPI[64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                  38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                  36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                  34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};

  des_perm_pipe #(.PIPE_STAGES(2), .OUT_SWAP(1'b0)) dut0 (
    .CLK(clk), .RESET(rst[0]), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
    .DATA_IN(din[0]), .MODE_IN(mode[0]), .TAG_IN(tin[0]), .OUT_VALID(out_valid[0]),
    .OUT_READY(out_ready[0]), .LEFT(left[0]), .RIGHT(right[0]), .TAG_OUT(tag_out[0]),
    .OCCUPANCY(occ[0]));
  des_perm_pipe #(.PIPE_STAGES(4), .OUT_SWAP(1'b0)) dut1 (
    .CLK(clk), .RESET(rst[1]), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
    .DATA_IN(din[1]), .MODE_IN(mode[1]), .TAG_IN(tin[1]), .OUT_VALID(out_valid[1]),
    .OUT_READY(out_ready[1]), .LEFT(left[1]), .RIGHT(right[1]), .TAG_OUT(tag_out[1]),
    .OCCUPANCY(occ[1]));
  des_perm_pipe #(.PIPE_STAGES(1), .OUT_SWAP(1'b1)) dut2 (
    .CLK(clk), .RESET(rst[2]), .IN_VALID(in_valid[2]), .IN_READY(in_ready[2]),
    .DATA_IN(din[2]), .MODE_IN(mode[2]), .TAG_IN(tin[2]), .OUT_VALID(out_valid[2]),
    .OUT_READY(out_ready[2]), .LEFT(left[2]), .RIGHT(right[2]), .TAG_OUT(tag_out[2]),
    .OCCUPANCY(occ[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
  endfunction

  function automatic bit sw_of(input int d);
    return (d == 2);
  endfunction

  function automatic logic [63:0] swp(input logic [63:0] x);
    return {x[31:0], x[63:32]};
  endfunction

  function automatic logic [63:0] model(input logic [63:0] x, input logic m, input bit sw);
    logic [63:0] p;
    for (int i = 1; i <= 64; i++) begin
      p[64 - i] = x[64 - (m ? IPI[i-1] : IPT[i-1])];
    end
    return sw ? swp(p) : p;
  endfunction

  function automatic logic [63:0] pat(input int i, input int d);
    return {32'h0123_4567 + 32'(i * 32'h1111_1111), 32'h89AB_CDEF ^ 32'(i * 32'h0F0F_1357 + d)};
  endfunction

  // Observe one cycle: sample just before the rising edge, then move to the next falling edge.
  task automatic cyc(input int d, output bit fin, output bit fout, output bit ov,
                     output logic [63:0] ob, output logic [3:0] ot);
    #1;
    fin  = in_valid[d] && in_ready[d];
    fout = out_valid[d] && out_ready[d];
    ov   = out_valid[d];
    ob   = {left[d], right[d]};
    ot   = tag_out[d];
    @(negedge clk);
  endtask

  task automatic run_one(input int d, input logic [63:0] x, input logic m, input logic [3:0] t,
                         output logic [63:0] got, output logic [3:0] gt, output int lat);
    bit fin, fout, ov;
    logic [63:0] ob;
    logic [3:0] ot;
    int k;
    out_ready[d] = 1'b1;
    din[d] = x; mode[d] = m; tin[d] = t; in_valid[d] = 1'b1;
    k = 0;
    do begin
      cyc(d, fin, fout, ov, ob, ot);
      k++;
    end while (!fin && k < 20);
    in_valid[d] = 1'b0;
    lat = -1; got = '0; gt = '0;
    if (fin) begin
      for (int c = 1; c <= 20; c++) begin
        cyc(d, fin, fout, ov, ob, ot);
        if (fout) begin
          lat = c; got = ob; gt = ot;
          break;
        end
      end
    end
  endtask

  task automatic test_reset(input int d);
    rst[d] = 1'b1; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
    repeat (2) @(negedge clk);
    rst[d] = 1'b0;
    #1;
    checks++; if (out_valid[d] !== 1'b0) $display("FAIL reset_out_valid dut%0d got %b want 0", d, out_valid[d]); else passes++;
    checks++; if (occ[d] !== 3'd0) $display("FAIL reset_occupancy dut%0d got %0d want 0", d, occ[d]); else passes++;
    checks++; if ({left[d], right[d], tag_out[d]} !== 68'h0) $display("FAIL reset_data dut%0d got %h want 0", d, {left[d], right[d], tag_out[d]}); else passes++;
    checks++; if (in_ready[d] !== 1'b1) $display("FAIL reset_in_ready dut%0d got %b want 1", d, in_ready[d]); else passes++;
    @(negedge clk);
  endtask

  task automatic test_ip_vector(input int d);
    logic [63:0] got, want;
    logic [3:0] gt;
    int lat;
    want = sw_of(d) ? 64'hF0AAF0AA_CC00CCFF : 64'hCC00CCFF_F0AAF0AA;
    run_one(d, 64'h0123456789ABCDEF, 1'b0, 4'hA, got, gt, lat);
    checks++; if (lat !== lat_of(d)) $display("FAIL ip_latency dut%0d got %0d want %0d", d, lat, lat_of(d)); else passes++;
    checks++; if (got !== want) $display("FAIL ip_vector dut%0d got %h want %h", d, got, want); else passes++;
    checks++; if (gt !== 4'hA) $display("FAIL ip_tag dut%0d got %h want a", d, gt); else passes++;
  endtask

  task automatic test_inverse(input int d);
    logic [63:0] got, want, x, p, z;
    logic [3:0] gt;
    int lat;
    want = sw_of(d) ? 64'h89ABCDEF_01234567 : 64'h0123456789ABCDEF;
    run_one(d, 64'hCC00CCFFF0AAF0AA, 1'b1, 4'h3, got, gt, lat);
    checks++; if (got !== want) $display("FAIL inv_vector dut%0d got %h want %h", d, got, want); else passes++;
    for (int r = 0; r < 3; r++) begin
      x = {$urandom, $urandom};
      run_one(d, x, 1'b0, 4'(r), got, gt, lat);
      checks++; if (got !== model(x, 1'b0, sw_of(d))) $display("FAIL rt_fwd dut%0d got %h want %h", d, got, model(x, 1'b0, sw_of(d))); else passes++;
      p = sw_of(d) ? swp(got) : got;
      run_one(d, p, 1'b1, 4'(r), got, gt, lat);
      z = sw_of(d) ? swp(got) : got;
      checks++; if (z !== x) $display("FAIL rt_inv dut%0d got %h want %h", d, z, x); else passes++;
    end
  endtask

  task automatic test_back_to_back(input int d);
    logic [67:0] q[$];
    logic [67:0] e;
    logic [63:0] ob;
    logic [3:0] ot;
    bit fin, fout, ov;
    int sent = 0, got = 0, stalls = 0, first_c = -1, last_c = -1, c = 0;
    out_ready[d] = 1'b1;
    while ((sent < 16 || got < 16) && c < 60) begin
      in_valid[d] = (sent < 16);
      if (sent < 16) begin
        din[d] = pat(sent, d); mode[d] = sent[0]; tin[d] = 4'(sent);
      end
      e = {model(din[d], mode[d], sw_of(d)), tin[d]};
      cyc(d, fin, fout, ov, ob, ot);
      if (sent < 16 && !fin) stalls++;
      if (fin) begin
        q.push_back(e);
        sent++;
      end
      if (fout) begin
        e = (q.size() > 0) ? q.pop_front() : 68'hx;
        checks++; if ({ob, ot} !== e) $display("FAIL stream_out%0d dut%0d got %h want %h", got, d, {ob, ot}, e); else passes++;
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      c++;
    end
    in_valid[d] = 1'b0;
    checks++; if (stalls !== 0) $display("FAIL stream_in_ready dut%0d got %0d stalls want 0", d, stalls); else passes++;
    checks++; if (got !== 16) $display("FAIL stream_count dut%0d got %0d want 16", d, got); else passes++;
    checks++; if (last_c - first_c !== 15) $display("FAIL stream_gapless dut%0d got span %0d want 15", d, last_c - first_c); else passes++;
  endtask

  task automatic test_backpressure(input int d);
    logic [67:0] q[$];
    logic [67:0] e, held;
    logic [63:0] ob;
    logic [3:0] ot;
    bit fin, fout, ov, seen;
    int acc = 0, unstable = 0, got = 0;
    seen = 1'b0; held = '0;
    out_ready[d] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid[d] = 1'b1;
      din[d] = pat(100 + acc, d); mode[d] = acc[0]; tin[d] = 4'(acc + 3);
      e = {model(din[d], mode[d], sw_of(d)), tin[d]};
      cyc(d, fin, fout, ov, ob, ot);
      if (fin) begin
        q.push_back(e);
        acc++;
      end
      if (ov) begin
        if (!seen) begin
          seen = 1'b1;
          held = {ob, ot};
        end else if ({ob, ot} !== held) begin
          unstable++;
        end
      end
    end
    checks++; if (acc !== lat_of(d)) $display("FAIL bp_accepts dut%0d got %0d want %0d", d, acc, lat_of(d)); else passes++;
    checks++; if (occ[d] !== 3'(lat_of(d))) $display("FAIL bp_occupancy dut%0d got %0d want %0d", d, occ[d], lat_of(d)); else passes++;
    checks++; if (in_ready[d] !== 1'b0) $display("FAIL bp_in_ready dut%0d got %b want 0", d, in_ready[d]); else passes++;
    checks++; if (out_valid[d] !== 1'b1) $display("FAIL bp_out_valid dut%0d got %b want 1", d, out_valid[d]); else passes++;
    checks++; if (unstable !== 0) $display("FAIL bp_stable dut%0d got %0d changes want 0", d, unstable); else passes++;
    e = (q.size() > 0) ? q[0] : 68'hx;
    checks++; if (held !== e) $display("FAIL bp_held dut%0d got %h want %h", d, held, e); else passes++;
    in_valid[d] = 1'b0; out_ready[d] = 1'b1;
    for (int c = 0; c < 20 && got < acc; c++) begin
      cyc(d, fin, fout, ov, ob, ot);
      if (fout) begin
        e = (q.size() > 0) ? q.pop_front() : 68'hx;
        checks++; if ({ob, ot} !== e) $display("FAIL bp_drain%0d dut%0d got %h want %h", got, d, {ob, ot}, e); else passes++;
        got++;
      end
    end
    checks++; if (got !== lat_of(d)) $display("FAIL bp_drain_count dut%0d got %0d want %0d", d, got, lat_of(d)); else passes++;
    checks++; if (occ[d] !== 3'd0) $display("FAIL bp_drain_occ dut%0d got %0d want 0", d, occ[d]); else passes++;
  endtask

  task automatic test_reset_midflight(input int d);
    logic [63:0] ob, got, x;
    logic [3:0] ot, gt;
    bit fin, fout, ov;
    int target, k, lat;
    target = (lat_of(d) < 2) ? lat_of(d) : 2;
    out_ready[d] = 1'b0;
    k = 0;
    do begin
      in_valid[d] = 1'b1;
      din[d] = pat(200 + k, d); mode[d] = 1'b0; tin[d] = 4'hF;
      cyc(d, fin, fout, ov, ob, ot);
      k++;
    end while (occ[d] !== 3'(target) && k < 10);
    in_valid[d] = 1'b0;
    checks++; if (occ[d] !== 3'(target)) $display("FAIL mid_fill dut%0d got %0d want %0d", d, occ[d], target); else passes++;
    rst[d] = 1'b1; out_ready[d] = 1'b1;
    #1;
    checks++; if (out_valid[d] !== 1'b0) $display("FAIL mid_no_xfer dut%0d got %b want 0", d, out_valid[d]); else passes++;
    @(negedge clk);
    checks++; if (occ[d] !== 3'd0) $display("FAIL mid_occ dut%0d got %0d want 0", d, occ[d]); else passes++;
    checks++; if ({left[d], right[d], tag_out[d]} !== 68'h0) $display("FAIL mid_data dut%0d got %h want 0", d, {left[d], right[d], tag_out[d]}); else passes++;
    rst[d] = 1'b0;
    #1;
    checks++; if (out_valid[d] !== 1'b0) $display("FAIL mid_out_valid dut%0d got %b want 0", d, out_valid[d]); else passes++;
    checks++; if (in_ready[d] !== 1'b1) $display("FAIL mid_in_ready dut%0d got %b want 1", d, in_ready[d]); else passes++;
    x = pat(300, d);
    run_one(d, x, 1'b1, 4'h9, got, gt, lat);
    checks++; if (lat !== lat_of(d)) $display("FAIL mid_latency dut%0d got %0d want %0d", d, lat, lat_of(d)); else passes++;
    checks++; if ({got, gt} !== {model(x, 1'b1, sw_of(d)), 4'h9}) $display("FAIL mid_data_after dut%0d got %h want %h", d, {got, gt}, {model(x, 1'b1, sw_of(d)), 4'h9}); else passes++;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
      din[d] = '0; mode[d] = 1'b0; tin[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      test_reset(d);
      test_ip_vector(d);
      test_inverse(d);
      test_back_to_back(d);
      test_backpressure(d);
      test_reset_midflight(d);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached after %0d/%0d checks", passes, checks);
    $fatal(1);
  end

endmodule
